// File: rtl/fp_pkg.sv
// Shared types for the FP issue controller.
// Track entries size the tag for the largest supported DEPTH (8).
package fp_pkg;

    localparam int unsigned FP_TAG_MAX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fp_ctrl_state_e;

    typedef struct packed {
        logic [FP_TAG_MAX_W-1:0] tag;
        logic [4:0]              rd;
        logic                    fp_wr;
        logic                    int_wr;
    } fp_track_t;

endpackage

// File: rtl/fp_track_fifo.sv
// In-order tracking FIFO for outstanding FPU operations.
// Pointers carry one extra wrap bit to separate full from empty.
module fp_track_fifo
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clr_i,
    input  logic      push_i,
    input  fp_track_t data_i,
    input  logic      pop_i,
    output fp_track_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fp_track_t      mem_q [DEPTH];
    logic [PTR_W:0] wptr_q, wptr_d;
    logic [PTR_W:0] rptr_q, rptr_d;
    logic           do_push;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign data_o  = mem_q[rptr_q[PTR_W-1:0]];
    assign do_push = push_i && !full_o && !clr_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push)
                wptr_d = wptr_q + (PTR_W+1)'(1);
            if (pop_i && !empty_o)
                rptr_d = rptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push)
                mem_q[wptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issue sequencer between FP decode and the fpnew FPU: hazard
// stalls, tag tracking and in-order result steering.
module fp_issue_ctrl
    import fp_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dec_valid_i,
    output logic             dec_ready_o,
    input  logic [14:0]      dec_rs_i,
    input  logic [2:0]       dec_rs_used_i,
    input  logic [4:0]       dec_rd_i,
    input  logic             dec_fp_wr_i,
    input  logic             dec_int_wr_i,
    output logic             fpu_in_valid_o,
    input  logic             fpu_in_ready_i,
    output logic [TAG_W-1:0] fpu_tag_o,
    input  logic             fpu_out_valid_i,
    output logic             fpu_out_ready_o,
    input  logic [TAG_W-1:0] fpu_tag_i,
    output logic             fp_wb_en_o,
    output logic [4:0]       fp_wb_addr_o,
    output logic             int_wb_req_o,
    input  logic             int_wb_gnt_i,
    output logic [4:0]       int_wb_addr_o,
    input  logic             flush_i,
    output logic             fpu_flush_o,
    output logic             busy_o,
    output logic             tag_err_o
);

    fp_ctrl_state_e   state_q, state_d;
    logic             iss_valid_q, iss_valid_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      busy_q, busy_d;
    logic             err_q, err_d;

    fp_track_t        push_ent, head;
    logic             fifo_full, fifo_empty, pop;
    logic             in_drain, accept, iss_hs, res_live;
    logic             raw, waw, structural;

    assign in_drain = (state_q == DRAIN);

    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < 3; k++)
            if (dec_rs_used_i[k] && busy_q[dec_rs_i[5*k +: 5]])
                raw = 1'b1;
    end

    assign waw        = dec_fp_wr_i && busy_q[dec_rd_i];
    // The issue slot counts as free when it drains this very cycle.
    assign structural = fifo_full || (iss_valid_q && !fpu_in_ready_i);

    assign dec_ready_o = !(raw || waw || structural) && !flush_i && !in_drain;
    assign accept      = dec_valid_i && dec_ready_o;

    assign fpu_in_valid_o = iss_valid_q && !in_drain;
    assign fpu_tag_o      = iss_tag_q;
    assign iss_hs         = fpu_in_valid_o && fpu_in_ready_i;

    assign push_ent.tag    = FP_TAG_MAX_W'(tag_q);
    assign push_ent.rd     = dec_rd_i;
    assign push_ent.fp_wr  = dec_fp_wr_i;
    assign push_ent.int_wr = dec_int_wr_i;

    fp_track_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (in_drain),
        .push_i  (accept),
        .data_i  (push_ent),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Results with nothing tracked (drain, post-flush stragglers) are dropped.
    assign res_live = fpu_out_valid_i && !fifo_empty && !in_drain;

    assign fpu_out_ready_o = fpu_out_valid_i &&
                             (!res_live || head.fp_wr ||
                              !head.int_wr || int_wb_gnt_i);
    assign pop             = res_live && fpu_out_ready_o;

    assign fp_wb_en_o    = pop && head.fp_wr;
    assign fp_wb_addr_o  = fp_wb_en_o ? head.rd : 5'd0;
    assign int_wb_req_o  = res_live && head.int_wr;
    assign int_wb_addr_o = int_wb_req_o ? head.rd : 5'd0;

    assign fpu_flush_o = in_drain;
    assign busy_o      = (state_q != IDLE);
    assign tag_err_o   = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (fifo_empty && !iss_valid_q && !accept)
                         state_d = IDLE;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = DRAIN;
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_tag_d   = iss_tag_q;
        tag_d       = tag_q;
        busy_d      = busy_q;
        err_d       = err_q;
        if (res_live && (head.tag != FP_TAG_MAX_W'(fpu_tag_i)))
            err_d = 1'b1;
        if (in_drain) begin
            iss_valid_d = 1'b0;
            busy_d      = '0;
        end else begin
            if (iss_hs)
                iss_valid_d = 1'b0;
            if (accept) begin
                iss_valid_d = 1'b1;
                iss_tag_d   = tag_q;
                tag_d       = tag_q + TAG_W'(1);
            end
            if (fp_wb_en_o)
                busy_d[head.rd] = 1'b0;
            // A new writer of the same register overrides the retiring one.
            if (accept && dec_fp_wr_i)
                busy_d[dec_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            iss_valid_q <= 1'b0;
            iss_tag_q   <= '0;
            tag_q       <= '0;
            busy_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            iss_valid_q <= iss_valid_d;
            iss_tag_q   <= iss_tag_d;
            tag_q       <= tag_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Scoreboard bench for fp_issue_ctrl: expected tags and writeback
// addresses are queued at accept and retired as the DUT emits them.
module tb_fp_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_fp, dec_iw;
    logic [14:0] dec_rs;
    logic [2:0]  dec_used;
    logic [4:0]  dec_rd;
    logic        in_ready, out_valid, gnt, flush;
    logic [1:0]  out_tag;
    logic        dec_ready_o, fpu_in_valid_o, fpu_out_ready_o;
    logic [1:0]  fpu_tag_o;
    logic        fp_wb_en_o, int_wb_req_o, fpu_flush_o, busy_o, tag_err_o;
    logic [4:0]  fp_wb_addr_o, int_wb_addr_o;

    always #5 clk = ~clk;

    fp_issue_ctrl #(.DEPTH(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .dec_valid_i     (dec_valid),
        .dec_ready_o     (dec_ready_o),
        .dec_rs_i        (dec_rs),
        .dec_rs_used_i   (dec_used),
        .dec_rd_i        (dec_rd),
        .dec_fp_wr_i     (dec_fp),
        .dec_int_wr_i    (dec_iw),
        .fpu_in_valid_o  (fpu_in_valid_o),
        .fpu_in_ready_i  (in_ready),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_out_valid_i (out_valid),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_tag_i       (out_tag),
        .fp_wb_en_o      (fp_wb_en_o),
        .fp_wb_addr_o    (fp_wb_addr_o),
        .int_wb_req_o    (int_wb_req_o),
        .int_wb_gnt_i    (gnt),
        .int_wb_addr_o   (int_wb_addr_o),
        .flush_i         (flush),
        .fpu_flush_o     (fpu_flush_o),
        .busy_o          (busy_o),
        .tag_err_o       (tag_err_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wb_cyc = 0;
    int acc_cyc = 0;

    logic [4:0] exp_fp[$];
    logic [4:0] exp_int[$];
    logic [1:0] exp_tag[$];
    logic [1:0] fly[$];
    logic [1:0] mtag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fp_wb_en_o) begin
                wb_cyc = cyc;
                if (exp_fp.size() == 0) chk("fp_wb_unexp", fp_wb_en_o, 0);
                else chk("fp_wb_addr", fp_wb_addr_o, exp_fp.pop_front());
            end
            if (fpu_in_valid_o && in_ready) begin
                if (exp_tag.size() == 0) chk("in_unexp", fpu_in_valid_o, 0);
                else chk("in_tag", fpu_tag_o, exp_tag.pop_front());
            end
            if (int_wb_req_o && gnt) begin
                if (exp_int.size() == 0) chk("int_unexp", int_wb_req_o, 0);
                else chk("int_addr_sb", int_wb_addr_o, exp_int.pop_front());
            end
        end
    end

    task automatic issue_op(input logic [4:0] rd, input logic [14:0] rs,
                            input logic [2:0] used, input logic fp,
                            input logic iw, output int stalls);
        int  n  = 0;
        bit  ok = 0;
        @(posedge clk); #1;
        dec_valid = 1'b1; dec_rd = rd; dec_rs = rs;
        dec_used = used; dec_fp = fp; dec_iw = iw;
        while (n < 60) begin
            @(negedge clk);
            if (dec_ready_o) begin ok = 1; break; end
            n++;
        end
        stalls = n;
        if (!ok) chk("acc_timeout", dec_ready_o, 1);
        else begin
            acc_cyc = cyc;
            exp_tag.push_back(mtag);
            fly.push_back(mtag);
            mtag = mtag + 2'd1;
            if (fp) exp_fp.push_back(rd);
            if (iw) exp_int.push_back(rd);
        end
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    task automatic fpu_ret(input logic [1:0] tag);
        int n = 0;
        @(posedge clk); #1;
        out_valid = 1'b1; out_tag = tag;
        while (n < 20) begin
            @(negedge clk);
            if (fpu_out_ready_o) break;
            n++;
        end
        if (n == 20) chk("ret_timeout", fpu_out_ready_o, 1);
        @(posedge clk); #1;
        out_valid = 1'b0;
    endtask

    task automatic ret_head();
        logic [1:0] t;
        t = (fly.size() != 0) ? fly.pop_front() : 2'd0;
        fpu_ret(t);
    endtask

    task automatic settle(input string tag);
        repeat (4) @(negedge clk);
        chk(tag, busy_o, 0);
        chk({tag, "_sb"}, exp_fp.size() + exp_int.size() + exp_tag.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [1:0] t;
        rst_n = 0; dec_valid = 0; dec_fp = 0; dec_iw = 0; dec_rs = '0;
        dec_used = '0; dec_rd = '0; in_ready = 0; out_valid = 0;
        gnt = 0; flush = 0; out_tag = '0; mtag = 2'd0;

        repeat (2) @(negedge clk);
        chk("rst_ready", dec_ready_o, 1);
        chk("rst_outs", {fpu_in_valid_o, fpu_out_ready_o, fp_wb_en_o,
                         int_wb_req_o, fpu_flush_o, busy_o, tag_err_o}, 0);
        chk("rst_addr", {fpu_tag_o, fp_wb_addr_o, int_wb_addr_o}, 0);
        @(posedge clk); #1 rst_n = 1;

        // single FADD
        in_ready = 1;
        issue_op(5'd5, 15'd0, 3'b000, 1, 0, st);
        chk("t1_nostall", st, 0);
        @(negedge clk);
        chk("t1_inval", fpu_in_valid_o, 1);
        chk("t1_busy", busy_o, 1);
        repeat (2) @(posedge clk);
        ret_head();
        settle("t1_idle");

        // RAW
        issue_op(5'd3, 15'd0, 3'b000, 1, 0, st);
        fork
            issue_op(5'd4, {10'd0, 5'd3}, 3'b001, 1, 0, st);
            begin repeat (4) @(posedge clk); ret_head(); end
        join
        chk("raw_stall", st >= 3, 1);
        chk("raw_gap", acc_cyc - wb_cyc, 1);
        ret_head();
        settle("t2_idle");

        // WAW
        issue_op(5'd6, 15'd0, 3'b000, 1, 0, st);
        fork
            issue_op(5'd6, 15'd0, 3'b000, 1, 0, st);
            begin repeat (3) @(posedge clk); ret_head(); end
        join
        chk("waw_stall", st >= 2, 1);
        ret_head();
        settle("waw_idle");

        // full FIFO
        for (int i = 0; i < 4; i++)
            issue_op(5'(10 + i), 15'd0, 3'b000, 1, 0, st);
        @(negedge clk);
        chk("full_rdy", dec_ready_o, 0);
        fork
            issue_op(5'd14, 15'd0, 3'b000, 1, 0, st);
            begin repeat (3) @(posedge clk); ret_head(); end
        join
        chk("full_stall", st >= 3, 1);
        repeat (4) ret_head();
        settle("t3_idle");

        // integer writeback
        issue_op(5'd10, 15'd0, 3'b000, 0, 1, st);
        @(posedge clk); #1;
        out_valid = 1; out_tag = fly.pop_front(); gnt = 0;
        repeat (2) begin
            @(negedge clk);
            chk("int_req", int_wb_req_o, 1);
            chk("int_hold", fpu_out_ready_o, 0);
        end
        @(posedge clk); #1 gnt = 1;
        @(negedge clk);
        chk("int_rdy", fpu_out_ready_o, 1);
        chk("int_addr", int_wb_addr_o, 10);
        @(posedge clk); #1 out_valid = 0; gnt = 0;
        // result with no destination is discarded
        issue_op(5'd9, 15'd0, 3'b000, 0, 0, st);
        ret_head();
        settle("t4_idle");

        // flush with 3 outstanding
        for (int i = 0; i < 3; i++)
            issue_op(5'(20 + i), 15'd0, 3'b000, 1, 0, st);
        @(posedge clk); #1 flush = 1;
        @(negedge clk);
        chk("fl_rdy0", dec_ready_o, 0);
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("fl_pulse", fpu_flush_o, 1);
        chk("fl_drain_rdy", dec_ready_o, 0);
        t = fly[0];
        fly.delete(); exp_fp.delete(); exp_tag.delete();
        @(negedge clk);
        chk("fl_pulse_end", fpu_flush_o, 0);
        chk("fl_busy", busy_o, 0);
        fpu_ret(t);
        chk("fl_late_err", tag_err_o, 0);
        issue_op(5'd23, {5'd22, 5'd21, 5'd20}, 3'b111, 1, 0, st);
        chk("fl_sb_clear", st, 0);
        @(negedge clk);
        chk("fl_busy_on", busy_o, 1);
        ret_head();
        settle("t5_idle");

        // tag mismatch
        issue_op(5'd7, 15'd0, 3'b000, 1, 0, st);
        t = fly.pop_front();
        fpu_ret(t + 2'd2);
        @(negedge clk);
        chk("tag_err", tag_err_o, 1);
        repeat (5) @(negedge clk);
        chk("tag_err_sticky", tag_err_o, 1);

        // reset mid-operation
        issue_op(5'd8, 15'd0, 3'b000, 1, 0, st);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_err", tag_err_o, 0);
        chk("mid_rst_busy", {busy_o, fpu_in_valid_o}, 0);
        exp_fp.delete(); exp_int.delete(); exp_tag.delete(); fly.delete();
        mtag = 2'd0;
        @(posedge clk); #1 rst_n = 1;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", dec_ready_o, 1);
        issue_op(5'd2, 15'd0, 3'b000, 1, 0, st);
        ret_head();
        settle("t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
